// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sharing one SRAM RW port between fetch (a) and load/store (b),
// with an optional zero-fill pass after reset.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_busy
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  typedef enum logic {S_RUN, S_INIT} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_last_a, r_rd_a, r_rd_b;
  logic                  w_init, w_run, w_pick_a;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
      r_cnt    <= '0;
      r_last_a <= 1'b0;
      r_rd_a   <= 1'b0;
      r_rd_b   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= (r_state == S_INIT) ? r_cnt + 1'b1 : '0;
      r_last_a <= a_gnt ? 1'b1 : b_gnt ? 1'b0 : r_last_a;
      r_rd_a   <= a_gnt && !a_we;
      r_rd_b   <= b_gnt && !b_we;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_cnt == LAST_ADDR) w_state_nxt = S_RUN;
  end
  // rst_n gates the combinational outputs so the port goes quiet the moment reset asserts
  assign w_init   = rst_n && (r_state == S_INIT);
  assign w_run    = rst_n && (r_state == S_RUN);
  assign w_pick_a = a_req && !(b_req && r_last_a);
  assign a_gnt    = w_run && w_pick_a;
  assign b_gnt    = w_run && b_req && !w_pick_a;
  assign init_busy   = w_init;
  assign sram_csb0   = !(w_init || a_gnt || b_gnt);
  assign sram_web0   = w_init ? 1'b0 : a_gnt ? !a_we : b_gnt ? !b_we : 1'b1;
  assign sram_addr0  = w_init ? r_cnt : a_gnt ? a_addr : b_gnt ? b_addr : '0;
  assign sram_din0   = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
  assign sram_wmask0 = w_init ? '1 : a_gnt ? a_wmask : b_gnt ? b_wmask : '0;
  assign a_rvalid = r_rd_a;
  assign b_rvalid = r_rd_b;
  assign a_rdata  = sram_dout0;
  assign b_rdata  = sram_dout0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random and directed traffic against a reference memory model with a scoreboard monitor.
module tb_sram_port_arbiter;
  localparam int DEPTH = 512;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0]  a_wmask = 0, b_wmask = 0;
  logic [8:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, init_busy;
  logic [31:0] a_rdata, b_rdata, sram_din0, sram_dout0;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic        u1_agnt, u1_bgnt, u1_arv, u1_brv, u1_csb, u1_web, u1_busy;
  logic [31:0] u1_ard, u1_brd, u1_din;
  logic [31:0] u1_dout = '0;
  logic [3:0]  u1_wm;
  logic [8:0]  u1_addr;

  always #5 clk = ~clk;

  sram_port_arbiter #(.CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0), .init_busy(init_busy));

  sram_port_arbiter #(.CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(u1_agnt), .a_rvalid(u1_arv), .a_rdata(u1_ard),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(u1_bgnt), .b_rvalid(u1_brv), .b_rdata(u1_brd),
    .sram_csb0(u1_csb), .sram_web0(u1_web), .sram_wmask0(u1_wm),
    .sram_addr0(u1_addr), .sram_din0(u1_din), .sram_dout0(u1_dout), .init_busy(u1_busy));

  // SRAM macro: inputs sampled on the rising edge; never-written words read back a recognisable non-zero pattern
  logic [31:0] sram [DEPTH];
  bit          sram_wr [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int l = 0; l < 4; l++) if (sram_wmask0[l]) sram[sram_addr0][8*l +: 8] <= sram_din0[8*l +: 8];
        sram_wr[sram_addr0] <= 1'b1;
      end else sram_dout0 <= sram_wr[sram_addr0] ? sram[sram_addr0] : (32'hA5A5_0000 | 32'(sram_addr0));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // directed expectations, keyed by cycle number; written only by the stimulus process
  logic [1:0]  dgnt [int];
  logic [31:0] drd  [int];

  typedef struct { int c; logic [31:0] d; } rd_t;
  rd_t         qa[$], qb[$], e;
  logic [31:0] ref_mem [DEPTH];
  int          init_idx = 0, vecs = 0, errs = 0;
  bit          last_a = 0, ra, rb, ea, eb, we;
  logic [8:0]  ad;
  logic [31:0] dn;
  logic [3:0]  wm;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", 64'({a_gnt, b_gnt}), 0);
      chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 0);
      chk("rst_csb", 64'(sram_csb0), 1);
      chk("rst_web", 64'(sram_web0), 1);
      chk("u1_rst_csb", 64'(u1_csb), 1);
      qa.delete(); qb.delete();
      last_a = 0; init_idx = 0;
    end else begin
      ra = qa.size() > 0 && qa[0].c == cyc;
      rb = qb.size() > 0 && qb[0].c == cyc;
      chk("a_rvalid", 64'(a_rvalid), 64'(ra));
      chk("b_rvalid", 64'(b_rvalid), 64'(rb));
      if (ra) begin e = qa.pop_front(); if (a_rvalid) chk("a_rdata", 64'(a_rdata), 64'(e.d)); end
      if (rb) begin e = qb.pop_front(); if (b_rvalid) chk("b_rdata", 64'(b_rdata), 64'(e.d)); end
      if (a_rvalid && drd.exists(cyc)) chk("a_rdata_dir", 64'(a_rdata), 64'(drd[cyc]));
      chk("u1_busy", 64'(u1_busy), 0);
      chk("u1_csb", 64'(u1_csb), 64'(!(a_req || b_req)));
      if (init_idx < DEPTH) begin
        chk("init_busy", 64'(init_busy), 1);
        chk("init_gnt", 64'({a_gnt, b_gnt}), 0);
        chk("init_csb_web", 64'({sram_csb0, sram_web0}), 0);
        chk("init_addr", 64'(sram_addr0), 64'(init_idx));
        chk("init_din_mask", 64'({sram_din0, sram_wmask0}), 64'h0F);
        ref_mem[init_idx] = '0;
        init_idx++;
      end else begin
        chk("busy", 64'(init_busy), 0);
        // a lone request always wins; on a tie the side that did not win last time goes
        ea = a_req && !(b_req && last_a);
        eb = b_req && !ea;
        if (dgnt.exists(cyc)) chk("gnt_dir", 64'({a_gnt, b_gnt}), 64'(dgnt[cyc]));
        chk("gnt", 64'({a_gnt, b_gnt}), 64'({ea, eb}));
        if (ea || eb) begin
          we = ea ? a_we : b_we;
          ad = ea ? a_addr : b_addr;
          dn = ea ? a_wdata : b_wdata;
          wm = ea ? a_wmask : b_wmask;
          chk("acc_csb_web", 64'({sram_csb0, sram_web0}), 64'({1'b0, !we}));
          chk("acc_addr", 64'(sram_addr0), 64'(ad));
          chk("acc_din_mask", 64'({sram_din0, sram_wmask0}), 64'({dn, wm}));
          if (we) begin
            for (int l = 0; l < 4; l++) if (wm[l]) ref_mem[ad][8*l +: 8] = dn[8*l +: 8];
          end else if (ea) qa.push_back('{cyc + 1, ref_mem[ad]});
          else qb.push_back('{cyc + 1, ref_mem[ad]});
          last_a = ea;
        end else begin
          chk("idle_csb", 64'(sram_csb0), 1);
          chk("idle_addr", 64'(sram_addr0), 0);
        end
      end
    end
  end

  bit ag, bg;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_a();
    a_req = $urandom_range(0, 3) != 0; a_we = $urandom_range(0, 1) != 0;
    a_addr = 9'($urandom_range(0, 15)); a_wdata = $urandom; a_wmask = 4'($urandom_range(0, 15));
  endtask
  task automatic rand_b();
    b_req = $urandom_range(0, 3) != 0; b_we = $urandom_range(0, 1) != 0;
    b_addr = 9'($urandom_range(0, 15)); b_wdata = $urandom; b_wmask = 4'($urandom_range(0, 15));
  endtask
  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ag = a_gnt; bg = b_gnt;
      tick();
      if (!a_req || ag) rand_a();
      if (!b_req || bg) rand_b();
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1;
    a_req = 1; a_we = 0; a_addr = 9'h1FF;
    b_req = 1; b_we = 0; b_addr = 9'h005;
    repeat (DEPTH) tick();
    for (int k = 0; k < 6; k++) begin
      dgnt[cyc] = (k % 2 == 0) ? 2'b10 : 2'b01;
      if (k == 0) drd[cyc + 1] = 32'h0;
      @(negedge clk); ag = a_gnt; bg = b_gnt;
      tick();
      if (ag) a_addr = 9'($urandom_range(0, DEPTH - 1));
      if (bg) b_addr = 9'($urandom_range(0, DEPTH - 1));
    end
    a_req = 0; b_req = 0;
    tick();
    a_req = 1; a_we = 0;
    for (int k = 0; k < 4; k++) begin
      dgnt[cyc] = 2'b10;
      a_addr = 9'(k + 32);
      tick();
    end
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 9'h010; b_wdata = 32'h1122_3344; b_wmask = 4'hF;
    tick();
    b_wdata = 32'hDEAD_BEEF; b_wmask = 4'b0011;
    tick();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 9'h010;
    dgnt[cyc] = 2'b10; drd[cyc + 1] = 32'h1122_BEEF;
    tick();
    a_req = 0;
    tick();
    rand_run(400);
    a_req = 0; b_req = 0;
    tick();
    a_req = 1; a_we = 0; a_addr = 9'h003;
    tick();
    a_req = 0; rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    rand_a(); rand_b(); a_req = 1; b_req = 1;
    repeat (100) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (DEPTH) tick();
    rand_run(150);
    a_req = 0; b_req = 0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
